// File: rtl/regfile_sb_if.sv
// regfile_sb_if -- bundle of the register-file / scoreboard signals.
//
// master : pipeline side. Drives the writeback, the read addresses and
//          operand-use flags, and the issue request. Receives read data,
//          stall and the pending count.
// slave  : register file side (regfile_sb).
//
// Signals
//   RegWr, Rd, WBus : writeback enable, destination address, data
//   Rs1, Rs2        : read addresses
//   Use1, Use2      : the read port's operand is consumed this cycle
//   Issue, IssueRd  : an instruction writing IssueRd enters the pipeline
//   Bus1, Bus2      : read data (combinational)
//   Stall           : a consumed operand still has a write outstanding
//   PendCnt         : number of registers with a write outstanding
interface regfile_sb_if #(
  parameter int WIDTH  = 16,
  parameter int ADDR_W = 3
);
  logic              RegWr;
  logic [ADDR_W-1:0] Rd;
  logic [WIDTH-1:0]  WBus;
  logic [ADDR_W-1:0] Rs1;
  logic [ADDR_W-1:0] Rs2;
  logic              Use1;
  logic              Use2;
  logic              Issue;
  logic [ADDR_W-1:0] IssueRd;
  logic [WIDTH-1:0]  Bus1;
  logic [WIDTH-1:0]  Bus2;
  logic              Stall;
  logic [ADDR_W:0]   PendCnt;

  modport master (
    output RegWr, Rd, WBus, Rs1, Rs2, Use1, Use2, Issue, IssueRd,
    input  Bus1, Bus2, Stall, PendCnt
  );

  modport slave (
    input  RegWr, Rd, WBus, Rs1, Rs2, Use1, Use2, Issue, IssueRd,
    output Bus1, Bus2, Stall, PendCnt
  );
endinterface

// File: rtl/regfile_sb.sv
// regfile_sb -- two-read / one-write register file with a pending-write
// scoreboard.
//
// Reads are combinational with write-first bypass from the writeback port.
// Each register carries a pending bit, set when an instruction targeting it
// issues and cleared when its writeback arrives. Stall flags a consumed
// operand whose register is pending and is not being written this cycle.
// PendCnt is a registered popcount of the pending vector.
//
// Ports
//   clk   : single clock, all state changes on the rising edge
//   reset : synchronous, active-high; clears data, pending bits and count
//   bus   : regfile_sb_if.slave (see the interface for signal meanings)
//
// Parameters
//   WIDTH    : register width in bits
//   ADDR_W   : address width; 2**ADDR_W registers
//   ZERO_REG : when 1, register 0 reads as zero and ignores writes/issues
module regfile_sb #(
  parameter int WIDTH    = 16,
  parameter int ADDR_W   = 3,
  parameter int ZERO_REG = 0
) (
  input logic          clk,
  input logic          reset,
  regfile_sb_if.slave  bus
);

  localparam int NREG = 2 ** ADDR_W;
  localparam bit ZR   = (ZERO_REG != 0);

  logic [WIDTH-1:0] rf [NREG];
  logic [NREG-1:0]  pending;
  logic [NREG-1:0]  pending_nxt;
  logic [ADDR_W:0]  pend_cnt;
  logic [ADDR_W:0]  pend_cnt_nxt;

  // Effective write/issue strobes: a hardwired-zero register swallows both.
  logic wr_en;
  logic iss_en;

  assign wr_en  = bus.RegWr && !(ZR && (bus.Rd == '0));
  assign iss_en = bus.Issue && !(ZR && (bus.IssueRd == '0));

  // Next pending vector: the writeback clears first, then a same-cycle issue
  // sets, so a new producer to the same register leaves it pending.
  always_comb begin
    // NOTE: every always_comb output gets a default on entry; a path that
    // leaves it unassigned would infer a latch.
    pending_nxt  = pending;
    pend_cnt_nxt = '0;
    if (wr_en)  pending_nxt[bus.Rd]      = 1'b0;
    if (iss_en) pending_nxt[bus.IssueRd] = 1'b1;
    for (int i = 0; i < NREG; i++) begin
      pend_cnt_nxt = pend_cnt_nxt + (ADDR_W + 1)'(pending_nxt[i]);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: the data array is reset as well as the control state, because
      // a read straight after reset must return zero; a storage array that
      // need not be initialised would normally be left out of reset.
      for (int i = 0; i < NREG; i++) rf[i] <= '0;
      pending  <= '0;
      pend_cnt <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      if (wr_en) rf[bus.Rd] <= bus.WBus;
      pending  <= pending_nxt;
      pend_cnt <= pend_cnt_nxt;
    end
  end

  assign bus.PendCnt = pend_cnt;

  // Read ports. Bypass is off during reset so the array itself is visible.
  logic byp1;
  logic byp2;
  logic hit1;
  logic hit2;

  always_comb begin
    byp1 = !reset && wr_en && (bus.Rd == bus.Rs1);
    byp2 = !reset && wr_en && (bus.Rd == bus.Rs2);

    bus.Bus1 = byp1 ? bus.WBus : rf[bus.Rs1];
    bus.Bus2 = byp2 ? bus.WBus : rf[bus.Rs2];
    // Register 0 may never have been reset yet; force zero explicitly.
    if (ZR && (bus.Rs1 == '0)) bus.Bus1 = '0;
    if (ZR && (bus.Rs2 == '0)) bus.Bus2 = '0;
  end

  // A writeback arriving this cycle satisfies the operand through bypass.
  // Register 0 is never pending when hardwired, so it can never stall.
  always_comb begin
    hit1 = bus.RegWr && (bus.Rd == bus.Rs1);
    hit2 = bus.RegWr && (bus.Rd == bus.Rs2);
    bus.Stall = !reset &&
                ((bus.Use1 && pending[bus.Rs1] && !hit1) ||
                 (bus.Use2 && pending[bus.Rs2] && !hit2));
  end

endmodule
